rtlmem_1rw2x_arb: RTL

//  Round-robin arbiter/sequencer sharing one single-port 2-cycle-read memory (1rw2x wrapper) among
//  G_NREQ requesters. One access (read or write) issued per cycle, read data returned with per-requester

---
 rtl/rtlmem_arb_pkg.sv | 20 ++
 rtl/rr_arb_core.sv | 35 +++
 rtl/rtlmem_1rw2x_arb.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/rtlmem_arb_pkg.sv
// rtl/rtlmem_arb_pkg.sv - shared types and constants for the 1rw2x memory arbiter
package rtlmem_arb_pkg;

   localparam int G_RD_LAT = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_CLR   = 2'd2,
      ST_WAIT  = 2'd3
   } clr_state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/rr_arb_core.sv
// rtl/rr_arb_core.sv - combinational round-robin pick from a request vector and start pointer
module rr_arb_core
   import rtlmem_arb_pkg::*;
#(
   parameter int G_NREQ = 4,
   localparam int ID_W = clog2(G_NREQ)
) (
   input  logic [G_NREQ-1:0] req,
   input  logic [ID_W-1:0]   ptr,
   output logic [G_NREQ-1:0] gnt,
   output logic [ID_W-1:0]   id,
   output logic              any
);

   int              idx;
   logic [ID_W-1:0] cand;

   always_comb begin
      gnt  = '0;
      id   = '0;
      any  = 1'b0;
      idx  = 0;
      cand = '0;
      for (int k = 0; k < G_NREQ; k++) begin
         idx  = (int'(ptr) + k) % G_NREQ;
         cand = ID_W'(idx);
         if (!any && req[cand]) begin
            any       = 1'b1;
            gnt[cand] = 1'b1;
            id        = cand;
         end
      end
   end

endmodule

// File: rtl/rtlmem_1rw2x_arb.sv
// rtl/rtlmem_1rw2x_arb.sv - round-robin sharing of one 2-cycle-read memory plus clear sequencing
module rtlmem_1rw2x_arb
   import rtlmem_arb_pkg::*;
#(
   parameter int G_NREQ  = 4,
   parameter int G_ADDR  = 10,
   parameter int G_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clr_req,
   output logic                        clr_busy,
   input  logic [G_NREQ-1:0]           rq_vld,
   input  logic [G_NREQ-1:0]           rq_we,
   input  logic [G_NREQ*G_ADDR-1:0]    rq_ad,
   input  logic [G_NREQ*G_WIDTH-1:0]   rq_di,
   output logic [G_NREQ-1:0]           rq_gnt,
   output logic [G_NREQ-1:0]           rd_vld,
   output logic [G_WIDTH-1:0]          rd_do,
   output logic [G_ADDR-1:0]           memad,
   output logic                        memwe,
   output logic [G_WIDTH-1:0]          memdi,
   output logic                        memre,
   input  logic [G_WIDTH-1:0]          memdo,
   output logic                        clren,
   input  logic                        clrrdy
);

   localparam int ID_W = clog2(G_NREQ);

   clr_state_e          st_q, st_d;
   logic                wcnt_q, wcnt_d;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [G_ADDR-1:0]   memad_q, memad_d;
   logic [G_WIDTH-1:0]  memdi_q, memdi_d;
   logic                memwe_q, memwe_d;
   logic                memre_q, memre_d;
   logic [ID_W-1:0]     iss_id_q, iss_id_d;
   logic [G_RD_LAT-1:0] rv_q, rv_d;
   logic [ID_W-1:0]     rid_q [G_RD_LAT];
   logic [ID_W-1:0]     rid_d [G_RD_LAT];

   logic [G_NREQ-1:0]   arb_gnt;
   logic [ID_W-1:0]     arb_id;
   logic                arb_any;
   logic                grant_en;
   logic                accept;
   logic                inflight;

   rr_arb_core #(.G_NREQ(G_NREQ)) u_core (
      .req (rq_vld),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .id  (arb_id),
      .any (arb_any)
   );

   // A clear request in IDLE takes priority over any pending command that cycle.
   assign grant_en = (st_q == ST_IDLE) && !clr_req;
   assign rq_gnt   = grant_en ? arb_gnt : '0;
   assign accept   = grant_en && arb_any;
   assign inflight = memre_q || (|rv_q);

   assign memad = memad_q;
   assign memdi = memdi_q;
   assign memwe = memwe_q;
   assign memre = memre_q;
   assign rd_do = memdo;

   always_comb begin
      ptr_d    = ptr_q;
      memad_d  = memad_q;
      memdi_d  = memdi_q;
      memwe_d  = 1'b0;
      memre_d  = 1'b0;
      iss_id_d = iss_id_q;
      if (accept) begin
         ptr_d    = (arb_id == ID_W'(G_NREQ - 1)) ? '0 : arb_id + 1'b1;
         memad_d  = rq_ad[int'(arb_id)*G_ADDR +: G_ADDR];
         memdi_d  = rq_di[int'(arb_id)*G_WIDTH +: G_WIDTH];
         memwe_d  = rq_we[arb_id];
         memre_d  = !rq_we[arb_id];
         iss_id_d = arb_id;
      end
   end

   // Return tags trail the issue register by the memory read latency.
   always_comb begin
      rv_d[0]  = memre_q;
      rid_d[0] = iss_id_q;
      for (int i = 1; i < G_RD_LAT; i++) begin
         rv_d[i]  = rv_q[i-1];
         rid_d[i] = rid_q[i-1];
      end
      rd_vld = '0;
      if (rv_q[G_RD_LAT-1]) rd_vld[rid_q[G_RD_LAT-1]] = 1'b1;
   end

   always_comb begin
      st_d     = st_q;
      wcnt_d   = wcnt_q;
      clren    = 1'b0;
      clr_busy = 1'b1;
      case (st_q)
         ST_IDLE: begin
            clr_busy = 1'b0;
            if (clr_req) st_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!inflight) st_d = ST_CLR;
         end
         ST_CLR: begin
            clren  = 1'b1;
            wcnt_d = 1'b0;
            st_d   = ST_WAIT;
         end
         ST_WAIT: begin
            wcnt_d = 1'b1;
            if (wcnt_q && clrrdy) st_d = ST_IDLE;
         end
         default: st_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q     <= ST_IDLE;
         wcnt_q   <= 1'b0;
         ptr_q    <= '0;
         memad_q  <= '0;
         memdi_q  <= '0;
         memwe_q  <= 1'b0;
         memre_q  <= 1'b0;
         iss_id_q <= '0;
         rv_q     <= '0;
         rid_q    <= '{default: '0};
      end else begin
         st_q     <= st_d;
         wcnt_q   <= wcnt_d;
         ptr_q    <= ptr_d;
         memad_q  <= memad_d;
         memdi_q  <= memdi_d;
         memwe_q  <= memwe_d;
         memre_q  <= memre_d;
         iss_id_q <= iss_id_d;
         rv_q     <= rv_d;
         rid_q    <= rid_d;
      end
   end

endmodule
